// File: rtl/fp32_minmax_stream_pkg.sv
// Shared definitions for the float32 min/max stream block and its lt comparator.
package fp32_minmax_stream_pkg;

    localparam int FP32_W = 32;
    localparam logic [7:0] EXP_ONES = 8'hFF;
    localparam int LT_LAT = 2;

    typedef enum logic [2:0] {
        ACCEPT,
        WAIT1,
        WAIT2,
        UPDATE,
        OUTPUT
    } mm_state_t;

    function automatic logic is_nan(input logic [FP32_W-1:0] v);
        return (v[30:23] == EXP_ONES) && (v[22:0] != 23'd0);
    endfunction

endpackage

// File: rtl/lt.sv
// Pipelined IEEE-754 single-precision a < b; NaN operands compare false, -0 equals +0.
module lt
    import fp32_minmax_stream_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic              clk,
    input  logic [FP32_W-1:0] a,
    input  logic [FP32_W-1:0] b,
    output logic              y
);

    logic           raw;
    logic [LAT-1:0] pipe;
    logic [30:0]    a_mag;
    logic [30:0]    b_mag;

    assign a_mag = a[30:0];
    assign b_mag = b[30:0];

    // Sign-magnitude ordering: negative magnitudes compare in reverse.
    always_comb begin
        raw = 1'b0;
        if (!is_nan(a) && !is_nan(b) && !((a_mag == 31'd0) && (b_mag == 31'd0))) begin
            if (a[31] != b[31])
                raw = a[31];
            else if (!a[31])
                raw = (a_mag < b_mag);
            else
                raw = (a_mag > b_mag);
        end
    end

    always_ff @(posedge clk) begin
        pipe[0] <= raw;
        for (int i = 1; i < LAT; i++)
            pipe[i] <= pipe[i-1];
    end

    assign y = pipe[LAT-1];

endmodule

// File: rtl/fp32_minmax_stream.sv
// Framed float32 stream reducer: running min/max with in-frame indices, one record per frame.
module fp32_minmax_stream #(
    parameter int IDX_W  = 16,
    parameter int LT_LAT = fp32_minmax_stream_pkg::LT_LAT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      mm_in,
    input  logic             mm_in_valid,
    input  logic             mm_in_last,
    output logic             mm_in_ready,
    output logic [31:0]      mm_min,
    output logic [31:0]      mm_max,
    output logic [IDX_W-1:0] mm_min_idx,
    output logic [IDX_W-1:0] mm_max_idx,
    output logic [IDX_W-1:0] mm_count,
    output logic             mm_all_nan,
    output logic             mm_out_valid,
    input  logic             mm_out_ready
);

    import fp32_minmax_stream_pkg::*;

    localparam logic [IDX_W-1:0] IDX_MAX = '1;

    mm_state_t         state, state_nxt;
    logic [31:0]       x;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  count;
    logic              last_q;
    logic              have;
    logic              in_fire;
    logic              in_nan;
    logic              x_lt_min;
    logic              max_lt_x;

    assign in_fire = mm_in_valid && mm_in_ready;
    assign in_nan  = is_nan(mm_in);

    // The comparators see x/min/max straight from registers that stay frozen
    // through WAIT1..UPDATE, so their outputs are only trusted in UPDATE.
    lt #(.LAT(LT_LAT)) u_lt_min (
        .clk (clk),
        .a   (x),
        .b   (mm_min),
        .y   (x_lt_min)
    );

    lt #(.LAT(LT_LAT)) u_lt_max (
        .clk (clk),
        .a   (mm_max),
        .b   (x),
        .y   (max_lt_x)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= ACCEPT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        mm_in_ready  = 1'b0;
        mm_out_valid = 1'b0;
        case (state)
            ACCEPT: begin
                mm_in_ready = 1'b1;
                if (in_fire) begin
                    if (in_nan || !have)
                        state_nxt = mm_in_last ? OUTPUT : ACCEPT;
                    else
                        state_nxt = WAIT1;
                end
            end
            WAIT1:  state_nxt = WAIT2;
            WAIT2:  state_nxt = UPDATE;
            UPDATE: state_nxt = last_q ? OUTPUT : ACCEPT;
            OUTPUT: begin
                mm_out_valid = 1'b1;
                if (mm_out_ready)
                    state_nxt = ACCEPT;
            end
            default: state_nxt = ACCEPT;
        endcase
    end

    // Datapath: count/index saturate so long frames still flow without wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x          <= '0;
            idx        <= '0;
            count      <= '0;
            last_q     <= 1'b0;
            have       <= 1'b0;
            mm_min     <= '0;
            mm_max     <= '0;
            mm_min_idx <= '0;
            mm_max_idx <= '0;
        end else begin
            case (state)
                ACCEPT: begin
                    if (in_fire) begin
                        x      <= mm_in;
                        idx    <= count;
                        last_q <= mm_in_last;
                        count  <= (count == IDX_MAX) ? count : count + 1'b1;
                        if (!in_nan && !have) begin
                            have       <= 1'b1;
                            mm_min     <= mm_in;
                            mm_max     <= mm_in;
                            mm_min_idx <= count;
                            mm_max_idx <= count;
                        end
                    end
                end
                UPDATE: begin
                    if (x_lt_min) begin
                        mm_min     <= x;
                        mm_min_idx <= idx;
                    end
                    if (max_lt_x) begin
                        mm_max     <= x;
                        mm_max_idx <= idx;
                    end
                end
                OUTPUT: begin
                    if (mm_out_ready) begin
                        count      <= '0;
                        have       <= 1'b0;
                        mm_min     <= '0;
                        mm_max     <= '0;
                        mm_min_idx <= '0;
                        mm_max_idx <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mm_count   = count;
    assign mm_all_nan = (state == OUTPUT) && !have;

endmodule

// File: tb/tb_fp32_minmax_stream.sv
// Scoreboard bench for fp32_minmax_stream: framed stimulus, modelled expectations, handshake timing.
module tb_fp32_minmax_stream;

    localparam int IDX_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [31:0]      mm_in = '0;
    logic             mm_in_valid = 1'b0;
    logic             mm_in_last = 1'b0;
    logic             mm_in_ready;
    logic [31:0]      mm_min;
    logic [31:0]      mm_max;
    logic [IDX_W-1:0] mm_min_idx;
    logic [IDX_W-1:0] mm_max_idx;
    logic [IDX_W-1:0] mm_count;
    logic             mm_all_nan;
    logic             mm_out_valid;
    logic             mm_out_ready = 1'b0;

    fp32_minmax_stream #(.IDX_W(IDX_W), .LT_LAT(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mm_in        (mm_in),
        .mm_in_valid  (mm_in_valid),
        .mm_in_last   (mm_in_last),
        .mm_in_ready  (mm_in_ready),
        .mm_min       (mm_min),
        .mm_max       (mm_max),
        .mm_min_idx   (mm_min_idx),
        .mm_max_idx   (mm_max_idx),
        .mm_count     (mm_count),
        .mm_all_nan   (mm_all_nan),
        .mm_out_valid (mm_out_valid),
        .mm_out_ready (mm_out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      mn;
        logic [31:0]      mx;
        logic [IDX_W-1:0] mn_idx;
        logic [IDX_W-1:0] mx_idx;
        logic [IDX_W-1:0] cnt;
        logic             all_nan;
    } result_t;

    result_t     exp_q[$];
    logic [31:0] frame_buf[$];
    logic [31:0] stim[$];
    int          waits[$];
    int          checks = 0;
    int          failures = 0;

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    function automatic logic model_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 0);
    endfunction

    // Maps non-NaN floats onto an unsigned total order with -0 folded into +0.
    function automatic logic [31:0] order_key(input logic [31:0] v);
        logic [31:0] w;
        w = (v == 32'h8000_0000) ? 32'h0 : v;
        return w[31] ? ~w : (w | 32'h8000_0000);
    endfunction

    function automatic result_t model_frame();
        result_t r;
        logic    have;
        r = '{mn: 0, mx: 0, mn_idx: 0, mx_idx: 0, cnt: 0, all_nan: 0};
        have = 1'b0;
        foreach (frame_buf[i]) begin
            logic [31:0] v;
            v = frame_buf[i];
            if (r.cnt != {IDX_W{1'b1}}) r.cnt = r.cnt + 1'b1;
            if (model_nan(v)) continue;
            if (!have) begin
                have = 1'b1;
                r.mn = v; r.mx = v;
                r.mn_idx = IDX_W'(i); r.mx_idx = IDX_W'(i);
            end else begin
                if (order_key(v) < order_key(r.mn)) begin r.mn = v; r.mn_idx = IDX_W'(i); end
                if (order_key(r.mx) < order_key(v)) begin r.mx = v; r.mx_idx = IDX_W'(i); end
            end
        end
        r.all_nan = !have;
        return r;
    endfunction

    // Called #1 after a rising edge; returns how many cycles ready stayed low.
    task automatic send_sample(input logic [31:0] v, input logic last, output int wait_cycles);
        mm_in = v;
        mm_in_last = last;
        mm_in_valid = 1'b1;
        wait_cycles = 0;
        while (!mm_in_ready && wait_cycles < 50) begin
            @(posedge clk); #1;
            wait_cycles++;
        end
        if (!mm_in_ready) check_output("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        frame_buf.push_back(v);
        if (last) begin
            mm_in_valid = 1'b0;
            mm_in_last = 1'b0;
        end
    endtask

    task automatic apply_stimulus(input logic [31:0] samples[$]);
        int w;
        frame_buf.delete();
        waits.delete();
        foreach (samples[i]) begin
            send_sample(samples[i], (i == samples.size() - 1), w);
            waits.push_back(w);
        end
        exp_q.push_back(model_frame());
    endtask

    task automatic receive_result(input string tag, input int hold);
        int      n;
        result_t e;
        logic [31:0] s_min, s_max;
        logic [IDX_W-1:0] s_cnt;
        n = 0;
        while (!mm_out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!mm_out_valid) check_output({tag, "_out_valid_timeout"}, 32'd0, 32'd1);
        s_min = mm_min; s_max = mm_max; s_cnt = mm_count;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check_output({tag, "_hold_min"}, mm_min, s_min);
            check_output({tag, "_hold_max"}, mm_max, s_max);
            check_output({tag, "_hold_cnt"}, 32'(mm_count), 32'(s_cnt));
            check_output({tag, "_hold_valid"}, 32'(mm_out_valid), 32'd1);
            check_output({tag, "_hold_in_ready"}, 32'(mm_in_ready), 32'd0);
        end
        if (exp_q.size() == 0) begin
            check_output({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_output({tag, "_min"}, mm_min, e.mn);
            check_output({tag, "_max"}, mm_max, e.mx);
            check_output({tag, "_min_idx"}, 32'(mm_min_idx), 32'(e.mn_idx));
            check_output({tag, "_max_idx"}, 32'(mm_max_idx), 32'(e.mx_idx));
            check_output({tag, "_count"}, 32'(mm_count), 32'(e.cnt));
            check_output({tag, "_all_nan"}, 32'(mm_all_nan), 32'(e.all_nan));
        end
        mm_out_ready = 1'b1;
        @(posedge clk); #1;
        mm_out_ready = 1'b0;
        check_output({tag, "_in_ready_after_hs"}, 32'(mm_in_ready), 32'd1);
        check_output({tag, "_valid_after_hs"}, 32'(mm_out_valid), 32'd0);
    endtask

    task automatic check_cleared(input string tag);
        check_output({tag, "_min"}, mm_min, 32'd0);
        check_output({tag, "_max"}, mm_max, 32'd0);
        check_output({tag, "_min_idx"}, 32'(mm_min_idx), 32'd0);
        check_output({tag, "_max_idx"}, 32'(mm_max_idx), 32'd0);
        check_output({tag, "_count"}, 32'(mm_count), 32'd0);
        check_output({tag, "_all_nan"}, 32'(mm_all_nan), 32'd0);
        check_output({tag, "_out_valid"}, 32'(mm_out_valid), 32'd0);
        check_output({tag, "_in_ready"}, 32'(mm_in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int w;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check_cleared("reset");

        // Ordinary frame with continuous valid: second sample compares, third waits 3 cycles.
        stim = '{32'h4040_0000, 32'hBF80_0000, 32'h40F0_0000};
        apply_stimulus(stim);
        check_output("ordinary_wait_s1", 32'(waits[1]), 32'd0);
        check_output("ordinary_wait_s2", 32'(waits[2]), 32'd3);
        receive_result("ordinary", 0);

        stim = '{32'h4000_0000, 32'h4000_0000};
        apply_stimulus(stim);
        receive_result("tie", 0);

        stim = '{32'h7F80_0000, 32'hFF80_0000};
        apply_stimulus(stim);
        receive_result("inf", 0);

        stim = '{32'h7FC0_0000, 32'h40A0_0000, 32'h7FC0_0000};
        apply_stimulus(stim);
        check_output("nan_wait_s2", 32'(waits[2]), 32'd0);
        receive_result("nan_mix", 0);

        stim = '{32'h7FC0_0000};
        apply_stimulus(stim);
        check_output("all_nan_latency", 32'(mm_out_valid), 32'd1);
        receive_result("all_nan", 0);

        stim = '{32'h4000_0000, 32'hC040_0000};
        apply_stimulus(stim);
        receive_result("backpressure", 5);

        stim = '{32'hC000_0000, 32'hC040_0000, 32'h0000_0000, 32'h8000_0000};
        apply_stimulus(stim);
        receive_result("neg_zero", 0);

        stim = '{32'h40A0_0000};
        apply_stimulus(stim);
        check_output("single_latency", 32'(mm_out_valid), 32'd1);
        receive_result("single", 0);

        for (int f = 0; f < 3; f++) begin
            stim.delete();
            for (int i = 0; i < 6; i++)
                stim.push_back((i == 2) ? 32'hFFC0_0001 : $urandom());
            apply_stimulus(stim);
            receive_result("random", 0);
        end

        // Reset while the second sample sits in WAIT1: frame must be discarded.
        frame_buf.delete();
        send_sample(32'h3F80_0000, 1'b0, w);
        mm_in = 32'h4000_0000;
        @(posedge clk); #1;
        check_output("midreset_in_wait1", 32'(mm_in_ready), 32'd0);
        rst_n = 1'b0;
        mm_in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_cleared("midreset");
        stim = '{32'h3F80_0000};
        apply_stimulus(stim);
        receive_result("post_reset", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
